// File: rtl/alu_seq_pkg.sv
// Shared types and command-byte field positions for the ALU op sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} seq_state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [1:0] sel;
  } alu_cmd_t;

  localparam int CMD_A_MSB   = 7;
  localparam int CMD_A_LSB   = 4;
  localparam int CMD_SEL_MSB = 3;
  localparam int CMD_SEL_LSB = 2;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous command queue; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate occupancy counter.
module seq_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_cmd_t wr_data,
  input  logic     pop,
  output alu_cmd_t rd_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  alu_cmd_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues UART command bytes and issues them one at a time to the 4-bit ALU,
// holding each result for a dwell period. Optional sticky flags: ALU_SEQ_STICKY_EN.
//
// state | meaning
// IDLE  | waiting for a queued command; pops and loads operands when one exists
// EXEC  | ALU settling; result and flags captured on the exiting edge
// HOLD  | result displayed for HOLD_CYCLES cycles
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int DROP_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  input  logic [1:0]        b_in,
  output logic [3:0]        alu_a,
  output logic [1:0]        alu_b,
  output logic [1:0]        alu_sel,
  input  logic [3:0]        alu_y,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        res_y,
  output logic [3:0]        res_flags,
  output logic              res_valid,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt,
  input  logic              clr_sticky,
  output logic [3:0]        sticky_flags
);

  localparam int              HCW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HCW-1:0]  HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  seq_state_t     state;
  logic [HCW-1:0] hold_cnt;
  alu_cmd_t       cmd_in;
  alu_cmd_t       cmd_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           fifo_push;
  logic           fifo_pop;

  assign cmd_in.a   = cmd_data[CMD_A_MSB:CMD_A_LSB];
  assign cmd_in.sel = cmd_data[CMD_SEL_MSB:CMD_SEL_LSB];

  // No bypass: a push into a full queue is dropped even if a pop happens this cycle.
  assign fifo_push = cmd_valid && !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign cmd_ready = !fifo_full && !rst;
  assign busy      = (state != IDLE) || !fifo_empty;

  seq_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (cmd_in),
    .pop     (fifo_pop),
    .rd_data (cmd_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_y     <= '0;
      res_flags <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            alu_a   <= cmd_head.a;
            alu_sel <= cmd_head.sel;
            alu_b   <= b_in;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_y     <= alu_y;
          res_flags <= alu_flags;
          res_valid <= 1'b1;
          hold_cnt  <= HOLD_LOAD;
          state     <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - HCW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     drop_cnt <= '0;
    else if (cmd_valid && fifo_full && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
  end

`ifdef ALU_SEQ_STICKY_EN
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_data[1:0];

  // Clear wins over a capture landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                sticky_flags <= '0;
    else if (clr_sticky)    sticky_flags <= '0;
    else if (state == EXEC) sticky_flags <= sticky_flags | alu_flags;
  end
`else
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^{cmd_data[1:0], clr_sticky};
  assign sticky_flags    = 4'b0000;
`endif

endmodule
